// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Holds the scan FSM state encoding, the hex segment table and a width helper.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  // gfedcba encoding, index is the hex nibble value
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int safe_clog2(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// Combinational hex nibble to 7-segment decoder (active-high, gfedcba).
module seg7_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_HEX[nib];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan scheduler with dead-time between digits and
// a shadow buffer that only commits at frame boundaries.
// Handshake: a word transfers on any edge where load_valid && load_ready;
// load_ready is simply !pending, and valid offered while not ready is dropped.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int CLK_FREQ     = 10000000,
  parameter int DIGIT_HZ     = 1000,
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DIV = CLK_FREQ / DIGIT_HZ;
  localparam int CW  = safe_clog2(DIV);
  localparam int IW  = safe_clog2(NUM_DIGITS);
  localparam int DW  = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         active_q, active_d;
  logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  logic                  frame_end;
  logic                  load_fire;
  logic [IW+1:0]         shamt;
  logic [3:0]            sel_nib;
  logic [6:0]            dec_seg;
  logic                  lz_hide;

  // Slot counter runs 0..DIV-1 across BLANK then SHOW of one digit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_end = 1'b0;
    case (state_q)
      OFF: begin
        cnt_d = '0;
        idx_d = '0;
        if (en) state_d = BLANK;
      end
      BLANK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BLANK_LAST) state_d = SHOW;
      end
      SHOW: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = '0;
          state_d = BLANK;
          if (idx_q == IDX_LAST) begin
            idx_d     = '0;
            frame_end = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = OFF;
    endcase
    if (!en) begin
      state_d   = OFF;
      cnt_d     = '0;
      idx_d     = '0;
      frame_end = 1'b0;
    end
    frame_done_d = frame_end;
  end

  assign load_ready = !pend_flag_q;
  assign load_fire  = load_valid && !pend_flag_q;

  // While OFF nothing is on screen, so words go straight to the active buffer.
  always_comb begin
    active_d    = active_q;
    active_dp_d = active_dp_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    if (state_q == OFF) begin
      if (pend_flag_q) begin
        active_d    = pend_q;
        active_dp_d = pend_dp_q;
        pend_flag_d = 1'b0;
      end else if (load_fire) begin
        active_d    = load_data;
        active_dp_d = load_dp;
      end
    end else begin
      if (frame_end && pend_flag_q) begin
        active_d    = pend_q;
        active_dp_d = pend_dp_q;
        pend_flag_d = 1'b0;
      end
      if (load_fire) begin
        pend_d      = load_data;
        pend_dp_d   = load_dp;
        pend_flag_d = 1'b1;
      end
    end
  end

  assign shamt   = {idx_d, 2'b00};
  assign sel_nib = active_d[shamt +: 4];
  assign lz_hide = lz_blank && (idx_d != '0) && ((active_d >> shamt) == '0);

  seg7_hex_decode u_dec (
    .nib (sel_nib),
    .seg (dec_seg)
  );

  // Outputs are computed from next-state so an/seg/dp flip on the same edge as the FSM.
  always_comb begin
    an_d  = '0;
    seg_d = '0;
    dp_d  = 1'b0;
    if (state_d == SHOW) begin
      an_d  = AN_ONE << idx_d;
      seg_d = lz_hide ? 7'h00 : dec_seg;
      dp_d  = active_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OFF;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      active_dp_q  <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      an_q         <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      active_dp_q  <= active_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan scheduler for a multi-digit 7-segment display.
- All digits share one segment bus; the block grants the bus to one digit at a time, with a dead-time gap between digits to suppress ghosting.
- Accepts a new display word via a valid/ready handshake into a shadow buffer. The buffer is committed only at frame boundaries, so a frame never shows mixed content.
- Sits between the counter/datapath logic and the uo_out pins of the top-level wrapper.

Parameters:
- CLK_FREQ, 10000000, input clock frequency in Hz.
- DIGIT_HZ, 1000, per-digit scan rate; DIV = CLK_FREQ/DIGIT_HZ cycles per digit slot.
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- BLANK_CYCLES, 16, dead-time cycles at the start of each slot; requires DIV > BLANK_CYCLES+1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, scan enable; 0 turns the display off.
- load_valid, input, 1, new display word offered.
- load_ready, output, 1, shadow buffer free.
- load_data, input, 4*NUM_DIGITS, hex nibbles; nibble i is digit i, and digit 0 is least significant.
- load_dp, input, NUM_DIGITS, decimal-point mask.
- lz_blank, input, 1, leading-zero blanking enable.
- seg, output, 7, segments, seg[0]=a .. seg[6]=g, active-high.
- dp, output, 1, decimal point, active-high.
- an, output, NUM_DIGITS, one-hot digit select, active-high.
- frame_done, output, 1, one-cycle pulse at the end of each full scan.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values:
  - state OFF, digit index 0.
  - active and pending buffers all zero, pending flag 0.
  - Outputs: an=0, seg=0, dp=0, frame_done=0, load_ready=1.
- Outputs are registered. an, seg and dp change together on the same edge.
- FSM OFF / BLANK / SHOW:
  - OFF: an, seg and dp are all 0; the slot counter is held at 0. When en=1, go to BLANK next cycle with idx=0.
  - BLANK: lasts exactly BLANK_CYCLES cycles with an=0, seg=0, dp=0, then go to SHOW.
  - SHOW: lasts exactly DIV-BLANK_CYCLES cycles with an=(1<<idx), seg=decode(active[idx]), dp=active_dp[idx], then go to BLANK with idx=idx+1.
  - Each digit slot is therefore exactly DIV cycles.
- Wrap: when SHOW ends at idx=NUM_DIGITS-1:
  - idx goes to 0.
  - frame_done pulses high for 1 cycle, coincident with the first BLANK cycle of the next frame.
  - If the pending flag is set, pending is copied to active on that same edge and the flag is cleared.
- en=0 in any state: next cycle OFF, outputs go to 0, idx goes to 0, no frame_done. Re-enable always restarts at digit 0 with a full BLANK.
- Handshake:
  - load_ready = !pending.
  - A transfer occurs on load_valid && load_ready.
  - In BLANK/SHOW, a transfer writes pending and sets the flag; load_ready drops the next cycle and rises the cycle after commit.
  - In OFF, a transfer writes active directly; the flag stays 0 and load_ready stays 1.
  - If the flag is set while OFF, pending commits on the next edge.
- load_valid while load_ready=0 is ignored; the data is not held or queued.
- Leading-zero blanking, when lz_blank=1:
  - A digit i>0 is blanked (seg=0) if active[i] and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
  - Blanking is evaluated on the active buffer.
- Decode is full hex, gfedcba encoding:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- rst mid-frame: everything returns to reset values on the next edge; the pending word is discarded.
- Counter width is $clog2(DIV); there is no arithmetic overflow, since the counter clears at end of slot.

Decomposition:
- Package seg_scan_pkg:
  - state enum {OFF, BLANK, SHOW}.
  - SEG_HEX[16] constant table.
  - function clog2-safe width helper.
- Sub-module seg7_hex_decode: combinational nibble to 7-bit segment decoder, instantiated once on the selected digit.
- Prescaler, FSM and buffers stay in seg_scan_ctrl.

Test Plan:
Bench params: CLK_FREQ=1000, DIGIT_HZ=100 (DIV=10), BLANK_CYCLES=2, NUM_DIGITS=4.
1. Reset and first slot: rst=1 for 3 cycles → an=0, seg=0, load_ready=1. Release with en=1 → first cycle OFF→BLANK, an=0 for 2 cycles, then an=0001, seg=3F for 8 cycles.
2. Load while OFF: en=0, load 0x1234 (dp=0000). Then en=1 → successive slots show an=0001/66, 0010/4F, 0100/5B, 1000/06. frame_done pulses every 40 cycles.
3. Mid-frame load: during the digit-1 slot, load 0x00AB → load_ready=0 next cycle and displayed digits are unchanged for the rest of the frame. On the frame_done edge the commit happens, the next digit 0 shows 7C, and load_ready=1 one cycle later. A second load_valid while not ready is ignored.
4. Leading-zero blanking: lz_blank=1, data 0x0050 → digit3 seg=00, digit2 seg=00, digit1 seg=6D, digit0 seg=3F. Data 0x0000 → only digit0 lit with 3F. A dp mask of 1000 still lights dp on blanked digit 3.
5. en drop mid-SHOW on digit 2 → next cycle an=0, seg=0, no frame_done. Re-enable → 2 blank cycles, then an=0001.
6. Sync reset with a pending word: load during a frame, then rst=1 for 1 cycle before the frame boundary → active and pending cleared, load_ready=1. After re-enable digit 0 shows 3F; the discarded word never appears.
